// File: rtl/wacc_pkg.sv
// -----------------------------------------------------------------------------
// wacc_pkg
// Shared fixed-point helpers for the weight-accumulation datapath.
//
// Values are handled in a wide internal format: operands are sign-extended to
// MAX_W bits, and intermediate products and sums to EXT_W bits, so that no
// supported word width can overflow before saturation. Word widths up to
// MAX_W-1 bits are supported.
//
// Contents:
//   FRAC_DEFAULT  : default number of fractional bits.
//   sat_max/min   : saturation limits for a w-bit two's-complement word.
//   sat_clamp     : clamp a wide value to w bits and report whether it clamped.
//   sat_shift_mul : (a*b) >>> frac (floor), then clamp to w bits.
// -----------------------------------------------------------------------------
package wacc_pkg;

  localparam int FRAC_DEFAULT = 24;
  localparam int MAX_W        = 64;
  localparam int EXT_W        = 2 * MAX_W;

  typedef logic signed [EXT_W-1:0] ext_t;

  typedef struct packed {
    logic                    sat;  // the value had to be clamped
    logic signed [MAX_W-1:0] val;  // clamped value, sign-extended to MAX_W
  } sat_res_t;

  // Largest w-bit value: 2^(w-1)-1.
  function automatic ext_t sat_max(input int unsigned w);
    return (ext_t'(1) <<< (w - 1)) - ext_t'(1);
  endfunction

  // Smallest w-bit value: -2^(w-1).
  function automatic ext_t sat_min(input int unsigned w);
    return -(ext_t'(1) <<< (w - 1));
  endfunction

  function automatic sat_res_t sat_clamp(input ext_t x, input int unsigned w);
    sat_res_t r;
    r = '0;
    if (x > sat_max(w)) begin
      r.sat = 1'b1;
      r.val = MAX_W'(sat_max(w));
    end else if (x < sat_min(w)) begin
      r.sat = 1'b1;
      r.val = MAX_W'(sat_min(w));
    end else begin
      r.val = MAX_W'(x);
    end
    return r;
  endfunction

  // Fixed-point multiply: the arithmetic right shift floors toward -inf,
  // which is exactly the truncation wanted for negative products.
  function automatic sat_res_t sat_shift_mul(input logic signed [MAX_W-1:0] a,
                                             input logic signed [MAX_W-1:0] b,
                                             input int unsigned            w,
                                             input int unsigned            frac);
    ext_t p;
    p = ext_t'(a) * ext_t'(b);
    return sat_clamp(p >>> frac, w);
  endfunction

endpackage

// File: rtl/wacc_lane.sv
// -----------------------------------------------------------------------------
// wacc_lane
// One weight channel: S1 = sat(d*a >>> FRAC), S2 = sat(S1*lr >>> FRAC),
// S3 = saturating accumulate. On batch completion the final sum goes to o and
// the accumulator restarts from zero. Sequencing (valid bits, count, clear)
// is owned by the top level so all lanes stay in lockstep.
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   i_s1_en/s2/s3_en  : stage load strobes for this cycle
//   i_done            : this S3 accumulation completes the batch
//   i_clr             : abort batch, zero the accumulator (o is held)
//   i_d, i_a          : this lane's delta and activation
//   i_lr              : learning rate registered alongside S1
//   o                 : last completed batch sum
//   o_sat             : a clamp happened in an enabled stage this cycle
// -----------------------------------------------------------------------------
module wacc_lane
  import wacc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = FRAC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_s1_en,
  input  logic             i_s2_en,
  input  logic             i_s3_en,
  input  logic             i_done,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_lr,
  output logic [WIDTH-1:0] o,
  output logic             o_sat
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] o_q, o_d;
  sat_res_t         s1_r, s2_r, s3_r;
  logic             unused_hi;

  // NOTE: every variable gets a default at the top of the block; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    s1_r = sat_shift_mul(MAX_W'($signed(i_d)), MAX_W'($signed(i_a)), WIDTH, FRAC);
    s2_r = sat_shift_mul(MAX_W'($signed(s1_q)), MAX_W'($signed(i_lr)), WIDTH, FRAC);
    s3_r = sat_clamp(EXT_W'($signed(acc_q)) + EXT_W'($signed(s2_q)), WIDTH);

    s1_d  = s1_q;
    s2_d  = s2_q;
    acc_d = acc_q;
    o_d   = o_q;

    if (i_s1_en) s1_d = s1_r.val[WIDTH-1:0];
    if (i_s2_en) s2_d = s2_r.val[WIDTH-1:0];

    if (i_clr) begin
      acc_d = '0;
    end else if (i_s3_en) begin
      if (i_done) begin
        o_d   = s3_r.val[WIDTH-1:0];
        acc_d = '0;
      end else begin
        acc_d = s3_r.val[WIDTH-1:0];
      end
    end
  end

  assign o_sat = (i_s1_en & s1_r.sat) | (i_s2_en & s2_r.sat) | (i_s3_en & s3_r.sat);

  // After clamping, the bits above WIDTH are pure sign copies.
  assign unused_hi = ^{s1_r.val[MAX_W-1:WIDTH], s2_r.val[MAX_W-1:WIDTH],
                       s3_r.val[MAX_W-1:WIDTH]};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      acc_q <= '0;
      o_q   <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      acc_q <= acc_d;
      o_q   <= o_d;
    end
  end

  assign o = o_q;

endmodule

// File: rtl/wght_acc_batch.sv
// -----------------------------------------------------------------------------
// wght_acc_batch
// CH-channel batched weight-update accumulator. For each accepted sample every
// channel computes p = d*a*lr in fixed point (FRAC fractional bits) and
// accumulates it with saturation. Every BATCH accumulations the sums are
// published on o with a one-cycle o_valid pulse, and accumulation restarts.
//
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   i_valid   : sample present on i_d / i_a / i_lr
//   i_d, i_a  : per-channel delta / activation, channel k at [k*WIDTH +: WIDTH]
//   i_lr      : learning rate shared by all channels
//   i_clr     : abort current batch (accumulators, count, pipeline, o_sat)
//   o         : last completed batch sums, same packing as i_d
//   o_valid   : one-cycle pulse when o is updated
//   o_sat     : sticky, any clamp anywhere since reset / last i_clr
//   o_cnt     : samples accumulated into the current batch
//
// Latency: a sample accepted at edge t is accumulated at edge t+2; a batch
// completing at that edge updates o and raises o_valid for the next cycle.
// -----------------------------------------------------------------------------
module wght_acc_batch
  import wacc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = FRAC_DEFAULT,
  parameter int CH    = 4,
  parameter int BATCH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [CH*WIDTH-1:0] i_d,
  input  logic [CH*WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0]    i_lr,
  input  logic                i_clr,
  output logic [CH*WIDTH-1:0] o,
  output logic                o_valid,
  output logic                o_sat,
  output logic [15:0]         o_cnt
);

  // 17 bits so BATCH = 2^16 is representable; the count itself never
  // exceeds BATCH-1.
  localparam logic [16:0] BATCH_L = 17'(BATCH);

  logic             s1_v_q, s1_v_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] lr_q, lr_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             o_valid_q, o_valid_d;
  logic             o_sat_q, o_sat_d;

  logic             s1_en, s2_en, s3_en, batch_done;
  logic [CH-1:0]    lane_sat;

  // i_clr gates every stage strobe, so a coincident sample or batch
  // completion is simply dropped.
  always_comb begin
    s1_en      = i_valid & ~i_clr;
    s2_en      = s1_v_q & ~i_clr;
    s3_en      = s2_v_q & ~i_clr;
    batch_done = s3_en & (({1'b0, cnt_q} + 17'd1) == BATCH_L);

    s1_v_d    = s1_en;
    s2_v_d    = s2_en;
    // lr travels with its sample so S2 multiplies by the matching rate.
    lr_d      = s1_en ? i_lr : lr_q;
    o_valid_d = batch_done;

    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (s3_en) begin
      cnt_d = batch_done ? 16'd0 : cnt_q + 16'd1;
    end

    o_sat_d = i_clr ? 1'b0 : (o_sat_q | (|lane_sat));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      lr_q      <= '0;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_sat_q   <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s2_v_q    <= s2_v_d;
      lr_q      <= lr_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      o_sat_q   <= o_sat_d;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    wacc_lane #(
      .WIDTH(WIDTH),
      .FRAC (FRAC)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_s1_en(s1_en),
      .i_s2_en(s2_en),
      .i_s3_en(s3_en),
      .i_done (batch_done),
      .i_clr  (i_clr),
      .i_d    (i_d[k*WIDTH +: WIDTH]),
      .i_a    (i_a[k*WIDTH +: WIDTH]),
      .i_lr   (lr_q),
      .o      (o[k*WIDTH +: WIDTH]),
      .o_sat  (lane_sat[k])
    );
  end

  assign o_valid = o_valid_q;
  assign o_sat   = o_sat_q;
  assign o_cnt   = cnt_q;

endmodule

// File: tb/tb_wght_acc_batch.sv
// -----------------------------------------------------------------------------
// tb_wght_acc_batch
// Bench for wght_acc_batch: one instance with BATCH=4 and one with BATCH=1,
// sharing all inputs. A negedge monitor logs every o_valid pulse (value and
// cycle); each test task compares that log and the status outputs against
// constants or a per-sample arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_wght_acc_batch;

  localparam int WIDTH = 32;
  localparam int FRAC  = 24;
  localparam int CH    = 4;
  localparam int VW    = CH * WIDTH;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  localparam logic [VW-1:0]    BASIC_D  = {4{32'h01000000}};
  localparam logic [VW-1:0]    BASIC_A  = {4{32'h00800000}};
  localparam logic [WIDTH-1:0] BASIC_LR = 32'h00400000;
  localparam logic [VW-1:0]    BASIC_O  = {4{32'h00800000}};
  localparam logic [VW-1:0]    SAT_O    = {96'h0, 32'h7FFFFFFF};

  logic            clk = 1'b0;
  logic            rst;
  logic            i_valid, i_clr;
  logic [VW-1:0]   i_d, i_a;
  logic [WIDTH-1:0] i_lr;

  logic [VW-1:0]   o4, o1;
  logic            ov4, ov1, os4, os1;
  logic [15:0]     oc4, oc1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [VW-1:0] obs_o[$], obs1_o[$], exp_q[$];
  int            obs_c[$], obs1_c[$];

  // reference model state (per sample, no pipeline)
  longint macc[CH];
  int     mcnt;
  bit     msat;

  wght_acc_batch #(.WIDTH(WIDTH), .FRAC(FRAC), .CH(CH), .BATCH(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_d(i_d), .i_a(i_a), .i_lr(i_lr),
    .i_clr(i_clr), .o(o4), .o_valid(ov4), .o_sat(os4), .o_cnt(oc4)
  );

  wght_acc_batch #(.WIDTH(WIDTH), .FRAC(FRAC), .CH(CH), .BATCH(1)) dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_d(i_d), .i_a(i_a), .i_lr(i_lr),
    .i_clr(i_clr), .o(o1), .o_valid(ov1), .o_sat(os1), .o_cnt(oc1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ov4 === 1'b1) begin obs_o.push_back(o4); obs_c.push_back(cyc); end
    if (ov1 === 1'b1) begin obs1_o.push_back(o1); obs1_c.push_back(cyc); end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage();
    i_d  = {$urandom, $urandom, $urandom, $urandom};
    i_a  = {$urandom, $urandom, $urandom, $urandom};
    i_lr = $urandom;
  endtask

  task automatic send(input logic [VW-1:0] d, input logic [VW-1:0] a,
                      input logic [WIDTH-1:0] lr, input logic clr);
    i_valid = 1'b1; i_clr = clr; i_d = d; i_a = a; i_lr = lr;
    tick();
    i_valid = 1'b0; i_clr = 1'b0;
    garbage();
  endtask

  task automatic clr_pulse();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
  endtask

  task automatic clear_logs();
    obs_o.delete(); obs_c.delete(); obs1_o.delete(); obs1_c.delete(); exp_q.delete();
  endtask

  function automatic longint clamp32(input longint x);
    if (x > MAXV) begin msat = 1'b1; return MAXV; end
    if (x < MINV) begin msat = 1'b1; return MINV; end
    return x;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < CH; k++) macc[k] = 0;
    mcnt = 0;
    msat = 1'b0;
  endtask

  task automatic model_sample(input logic [VW-1:0] d, input logic [VW-1:0] a,
                              input logic [WIDTH-1:0] lr);
    longint dk, ak, lv, t, p;
    logic [VW-1:0] v;
    lv = longint'($signed(lr));
    for (int k = 0; k < CH; k++) begin
      dk = longint'($signed(d[k*WIDTH +: WIDTH]));
      ak = longint'($signed(a[k*WIDTH +: WIDTH]));
      t  = clamp32((dk * ak) >>> FRAC);
      p  = clamp32((t * lv) >>> FRAC);
      macc[k] = clamp32(macc[k] + p);
    end
    mcnt++;
    if (mcnt == 4) begin
      for (int k = 0; k < CH; k++) begin
        v[k*WIDTH +: WIDTH] = macc[k][WIDTH-1:0];
        macc[k] = 0;
      end
      exp_q.push_back(v);
      mcnt = 0;
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    logic signed [WIDTH-1:0] t;
    t = $urandom;
    return t >>> $urandom_range(0, 12);
  endfunction

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst = 1'b0; i_valid = 1'b0; i_clr = 1'b0;
    garbage();
    #2;
    total++; if (o4 !== '0)    begin bad++; $display("FAIL reset_o: got %h want 0", o4); end
    total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ov4); end
    total++; if (os4 !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", os4); end
    total++; if (oc4 !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", oc4); end
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int e;
    clear_logs();
    for (int i = 0; i < 4; i++) send(BASIC_D, BASIC_A, BASIC_LR, 1'b0);
    e = cyc;
    repeat (5) tick();
    total++; if (obs_o.size() != 1) begin bad++; $display("FAIL basic_pulses: got %0d want 1", obs_o.size()); end
    if (obs_o.size() >= 1) begin
      total++; if (obs_o[0] !== BASIC_O) begin bad++; $display("FAIL basic_o: got %h want %h", obs_o[0], BASIC_O); end
      total++; if (obs_c[0] != e + 2) begin bad++; $display("FAIL basic_latency: got %0d want %0d", obs_c[0], e + 2); end
    end
    total++; if (os4 !== 1'b0) begin bad++; $display("FAIL basic_sat: got %b want 0", os4); end
    total++; if (oc4 !== 16'd0) begin bad++; $display("FAIL basic_cnt: got %0d want 0", oc4); end
  endtask

  task automatic test_continuous();
    clear_logs();
    for (int i = 0; i < 8; i++) send(BASIC_D, BASIC_A, BASIC_LR, 1'b0);
    repeat (5) tick();
    total++; if (obs_o.size() != 2) begin bad++; $display("FAIL cont_pulses: got %0d want 2", obs_o.size()); end
    if (obs_o.size() == 2) begin
      total++; if (obs_c[1] - obs_c[0] != 4) begin bad++; $display("FAIL cont_spacing: got %0d want 4", obs_c[1] - obs_c[0]); end
      total++; if (obs_o[0] !== BASIC_O) begin bad++; $display("FAIL cont_o0: got %h want %h", obs_o[0], BASIC_O); end
      total++; if (obs_o[1] !== BASIC_O) begin bad++; $display("FAIL cont_o1: got %h want %h", obs_o[1], BASIC_O); end
    end
  endtask

  task automatic test_saturation();
    clear_logs();
    for (int i = 0; i < 4; i++)
      send({96'h0, 32'h7F000000}, {96'h0, 32'h7F000000}, 32'h01000000, 1'b0);
    repeat (5) tick();
    total++; if (obs_o.size() != 1) begin bad++; $display("FAIL sat_pulses: got %0d want 1", obs_o.size()); end
    total++; if (o4 !== SAT_O) begin bad++; $display("FAIL sat_o: got %h want %h", o4, SAT_O); end
    total++; if (os4 !== 1'b1) begin bad++; $display("FAIL sat_flag: got %b want 1", os4); end
    clr_pulse();
    total++; if (os4 !== 1'b0) begin bad++; $display("FAIL sat_clr_flag: got %b want 0", os4); end
    total++; if (o4 !== SAT_O) begin bad++; $display("FAIL sat_clr_hold: got %h want %h", o4, SAT_O); end
  endtask

  task automatic test_clear();
    logic [VW-1:0] d, a;
    logic [WIDTH-1:0] lr;
    clear_logs();
    send(BASIC_D, BASIC_A, BASIC_LR, 1'b0);
    send(BASIC_D, BASIC_A, BASIC_LR, 1'b0);
    repeat (2) tick();
    total++; if (oc4 !== 16'd2) begin bad++; $display("FAIL clr_pre_cnt: got %0d want 2", oc4); end
    send(BASIC_D, BASIC_A, BASIC_LR, 1'b1);
    total++; if (oc4 !== 16'd0) begin bad++; $display("FAIL clr_cnt: got %0d want 0", oc4); end
    total++; if (o4 !== SAT_O) begin bad++; $display("FAIL clr_hold: got %h want %h", o4, SAT_O); end
    repeat (4) tick();
    total++; if (obs_o.size() != 0) begin bad++; $display("FAIL clr_no_pulse: got %0d want 0", obs_o.size()); end
    total++; if (oc4 !== 16'd0) begin bad++; $display("FAIL clr_dropped: got %0d want 0", oc4); end
    model_clear();
    for (int i = 0; i < 4; i++) begin
      d = {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
      a = {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
      lr = rnd_word();
      model_sample(d, a, lr);
      send(d, a, lr, 1'b0);
    end
    total++; if (o4 !== SAT_O) begin bad++; $display("FAIL clr_hold_late: got %h want %h", o4, SAT_O); end
    repeat (4) tick();
    total++; if (obs_o.size() != 1) begin bad++; $display("FAIL clr_new_pulses: got %0d want 1", obs_o.size()); end
    if (obs_o.size() == 1 && exp_q.size() == 1) begin
      total++; if (obs_o[0] !== exp_q[0]) begin bad++; $display("FAIL clr_new_o: got %h want %h", obs_o[0], exp_q[0]); end
    end
    total++; if (os4 !== msat) begin bad++; $display("FAIL clr_new_sat: got %b want %b", os4, msat); end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] d, a;
    logic [WIDTH-1:0] lr;
    clear_logs();
    send(BASIC_D, BASIC_A, BASIC_LR, 1'b0);
    send(BASIC_D, BASIC_A, BASIC_LR, 1'b0);
    rst = 1'b0;
    #1;
    total++; if (o4 !== '0)     begin bad++; $display("FAIL rstmid_o: got %h want 0", o4); end
    total++; if (ov4 !== 1'b0)  begin bad++; $display("FAIL rstmid_valid: got %b want 0", ov4); end
    total++; if (os4 !== 1'b0)  begin bad++; $display("FAIL rstmid_sat: got %b want 0", os4); end
    total++; if (oc4 !== 16'd0) begin bad++; $display("FAIL rstmid_cnt: got %0d want 0", oc4); end
    repeat (2) tick();
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      d = {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
      a = {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
      lr = rnd_word();
      model_sample(d, a, lr);
      send(d, a, lr, 1'b0);
      if (i == 2) begin
        repeat (5) tick();
        total++; if (obs_o.size() != 0) begin bad++; $display("FAIL rstmid_early: got %0d pulses want 0", obs_o.size()); end
        total++; if (oc4 !== 16'd3) begin bad++; $display("FAIL rstmid_cnt3: got %0d want 3", oc4); end
      end
    end
    repeat (4) tick();
    total++; if (obs_o.size() != 1) begin bad++; $display("FAIL rstmid_pulses: got %0d want 1", obs_o.size()); end
    if (obs_o.size() == 1 && exp_q.size() == 1) begin
      total++; if (obs_o[0] !== exp_q[0]) begin bad++; $display("FAIL rstmid_new_o: got %h want %h", obs_o[0], exp_q[0]); end
    end
  endtask

  task automatic test_batch1();
    int e;
    logic [VW-1:0] want;
    want = {4{32'hFF000000}};
    clear_logs();
    send({4{32'hFF000000}}, {4{32'h01000000}}, 32'h01000000, 1'b0);
    e = cyc;
    for (int i = 1; i < 4; i++) send({4{32'hFF000000}}, {4{32'h01000000}}, 32'h01000000, 1'b0);
    repeat (4) tick();
    total++; if (obs1_o.size() != 4) begin bad++; $display("FAIL b1_pulses: got %0d want 4", obs1_o.size()); end
    for (int i = 0; i < obs1_o.size() && i < 4; i++) begin
      total++; if (obs1_o[i] !== want) begin bad++; $display("FAIL b1_o%0d: got %h want %h", i, obs1_o[i], want); end
      total++; if (obs1_c[i] != e + 2 + i) begin bad++; $display("FAIL b1_cyc%0d: got %0d want %0d", i, obs1_c[i], e + 2 + i); end
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] d, a;
    logic [WIDTH-1:0] lr;
    clr_pulse();
    clear_logs();
    model_clear();
    total++; if (oc4 !== 16'd0) begin bad++; $display("FAIL rnd_start_cnt: got %0d want 0", oc4); end
    for (int i = 0; i < 26; i++) begin
      d = {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
      a = {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
      lr = rnd_word();
      model_sample(d, a, lr);
      send(d, a, lr, 1'b0);
      repeat ($urandom_range(0, 2) * ($urandom_range(0, 2) == 0 ? 1 : 0)) tick();
    end
    repeat (4) tick();
    total++; if (obs_o.size() != exp_q.size()) begin bad++; $display("FAIL rnd_pulses: got %0d want %0d", obs_o.size(), exp_q.size()); end
    for (int i = 0; i < obs_o.size() && i < exp_q.size(); i++) begin
      total++; if (obs_o[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_o%0d: got %h want %h", i, obs_o[i], exp_q[i]); end
    end
    total++; if (oc4 !== 16'(mcnt)) begin bad++; $display("FAIL rnd_cnt: got %0d want %0d", oc4, mcnt); end
    total++; if (os4 !== msat) begin bad++; $display("FAIL rnd_sat: got %b want %b", os4, msat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_continuous();
    test_saturation();
    test_clear();
    test_reset_mid();
    test_batch1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
